// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles stream bytes MSB-first into a word and keeps a running XOR checksum.
module byte_packer #(
  parameter int unsigned DataSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift,
  input  logic [7:0]          data,
  output logic                word_full,
  output logic [DataSize-1:0] word,
  output logic [7:0]          checksum
);
  import imem_loader_pkg::*;

  logic [1:0] idx;

  // Asserted on the transfer that completes a word; the assembled word is valid the cycle after.
  assign word_full = shift && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word     <= '0;
      idx      <= '0;
      checksum <= '0;
    end else if (shift) begin
      word     <= {word[DataSize-BYTE_W-1:0], data};
      idx      <= idx + 2'd1;
      checksum <= checksum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: framed byte stream -> instruction memory writes, core held in reset until verified.
module imem_loader #(
  parameter int DataSize = 32,
  parameter int PCsize   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [PCsize-1:0]   mem_addr,
  output logic [DataSize-1:0] mem_wd,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [PCsize:0]     words_loaded
);
  import imem_loader_pkg::*;

  localparam int unsigned     CAPACITY = 1 << PCsize;
  localparam logic [PCsize:0] WL_ONE   = (PCsize+1)'(1);

  state_t                state, state_nx;
  logic [PCsize:0]       count_n;
  logic [PCsize-1:0]     addr;
  logic [PCsize:0]       loaded_nx;
  logic                  xfer, last_word;
  logic                  load_start, count_ok, count_bad, write_word, check_ok, check_bad;
  logic                  word_full;
  logic [DataSize-1:0]   word;
  logic [7:0]            checksum;

  assign in_ready  = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign loaded_nx = words_loaded + WL_ONE;
  assign last_word = (loaded_nx == count_n);

  byte_packer #(.DataSize(DataSize)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .shift     (xfer && (state == S_DATA)),
    .data      (in_data),
    .word_full (word_full),
    .word      (word),
    .checksum  (checksum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_start = 1'b0;
    count_ok   = 1'b0;
    count_bad  = 1'b0;
    write_word = 1'b0;
    check_ok   = 1'b0;
    check_bad  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx   = S_COUNT;
          load_start = 1'b1;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (in_data == '0 || 32'(in_data) > CAPACITY) begin
            count_bad = 1'b1;
            state_nx  = S_ERR;
          end else begin
            count_ok  = 1'b1;
            state_nx  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_full) state_nx = S_WRITE;
      end
      S_WRITE: begin
        write_word = 1'b1;
        state_nx   = last_word ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == checksum) begin
            check_ok = 1'b1;
            state_nx = S_DONE;
          end else begin
            check_bad = 1'b1;
            state_nx  = S_ERR;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs and datapath follow the strobes decoded above so they stay in step with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst      <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wd       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      count_n      <= '0;
      addr         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (load_start) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        busy         <= 1'b1;
        cpu_rst      <= 1'b1;
      end
      if (count_ok) begin
        count_n <= (PCsize+1)'(in_data);
        addr    <= '0;
      end
      if (count_bad || check_bad) begin
        busy  <= 1'b0;
        error <= 1'b1;
      end
      if (write_word) begin
        mem_we       <= 1'b1;
        mem_addr     <= addr;
        mem_wd       <= word;
        addr         <= addr + PCsize'(1);
        words_loaded <= loaded_nx;
      end
      if (check_ok) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
    end
  end

endmodule
